y86_ifetch_ctrl: RTL

- Sequences instruction fetch for the Y86-64 sequential core.
- Owns the architectural PC. Reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake.
- Assembles a complete 1-10 byte instruction and presents it, with its length and valP, to the fetch/decode datapath over a valid/ready handshake.
- Applies PC redirects from execute (taken jXX, call, ret) and tracks processor status (AOK/HLT/ADR/INS).

---
 rtl/y86_pkg.sv | 59 +++++
 rtl/y86_ifetch_ctrl_if.sv | 47 ++++
 rtl/y86_instr_len.sv | 22 ++
 rtl/y86_ifetch_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 fetch path: icode constants, processor
// status encodings, fetch controller states and the instruction length
// decode function (also used by the fetch/decode datapath).
// ----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic [1:0] {
        S_FETCH0  = 2'd0,
        S_FETCHN  = 2'd1,
        S_PRESENT = 2'd2,
        S_STOP    = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic       invalid;
        logic [3:0] len;
    } len_info_t;

    // Instruction length from icode; ifun is deliberately not examined.
    function automatic len_info_t instr_len_f(input logic [3:0] icode);
        len_info_t r;
        r.invalid = 1'b0;
        r.len     = 4'd1;
        case (icode)
            I_HALT, I_NOP, I_RET:              r.len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  r.len = 4'd2;
            I_JXX, I_CALL:                     r.len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      r.len = 4'd10;
            default: begin
                r.invalid = 1'b1;
                r.len     = 4'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_ifetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// y86_ifetch_ctrl_if
// Bundles the instruction-memory req/ack bus, the instruction valid/ready
// bus to the datapath, the redirect inputs and the status outputs.
//   master : fetch controller side
//   slave  : memory / datapath / execute side
// ----------------------------------------------------------------------------
interface y86_ifetch_ctrl_if #(
    parameter int MAX_LEN = 10
);
    logic                   imem_req;
    logic [63:0]            imem_addr;
    logic                   imem_ack;
    logic [7:0]             imem_rdata;
    logic                   imem_err;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [8*MAX_LEN-1:0]   instr_bytes;
    logic [3:0]             instr_len;
    logic [63:0]            pc;
    logic [63:0]            valp;

    logic                   redirect_valid;
    logic [63:0]            redirect_pc;

    logic [1:0]             stat;
    logic                   halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, imem_err,
        output instr_valid, instr_bytes, instr_len, pc, valp,
        input  instr_ready,
        input  redirect_valid, redirect_pc,
        output stat, halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, imem_err,
        input  instr_valid, instr_bytes, instr_len, pc, valp,
        output instr_ready,
        output redirect_valid, redirect_pc,
        input  stat, halted
    );
endinterface

// File: rtl/y86_instr_len.sv
// ----------------------------------------------------------------------------
// y86_instr_len
// Combinational icode -> {len, invalid} decoder.
//   icode   : high nibble of instruction byte 0
//   len     : instruction length in bytes (1..10), 0 when invalid
//   invalid : icode 12..15
// ----------------------------------------------------------------------------
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       invalid
);
    len_info_t info;

    always_comb begin
        info    = instr_len_f(icode);
        len     = info.len;
        invalid = info.invalid;
    end
endmodule

// File: rtl/y86_ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// y86_ifetch_ctrl
// Instruction fetch sequencer for the Y86-64 sequential core. Owns the PC,
// reads instruction bytes one at a time over imem req/ack, assembles the
// instruction and hands it to the datapath over instr valid/ready, then
// advances the PC to valP or a redirect target.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : y86_ifetch_ctrl_if.master (imem, instr, redirect, stat/halted)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// FETCH0    | requesting byte 0 at pc, decode length on ack
// FETCHN    | requesting byte[count] at pc+count until count == length
// PRESENT   | instruction valid, waiting for instr_ready
// STOP      | halted (HLT/ADR/INS); only rst leaves
// ----------------------------------------------------------------------------
module y86_ifetch_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter int          MAX_LEN  = 10
) (
    input  logic                clk,
    input  logic                rst,
    y86_ifetch_ctrl_if.master   bus
);

    fetch_state_e           state_q, state_d;
    logic [63:0]            pc_q, pc_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             len_q, len_d;
    logic [8*MAX_LEN-1:0]   buf_q, buf_d;
    stat_e                  stat_q, stat_d;
    // Forces one request-free cycle after every ack, and keeps imem_req low
    // while rst is held.
    logic                   idle_q, idle_d;

    logic [3:0]             dec_len;
    logic                   dec_invalid;
    logic                   req_w;
    logic                   ack_ok;
    logic [3:0]             cnt_inc;

    y86_instr_len u_len (
        .icode   (bus.imem_rdata[7:4]),
        .len     (dec_len),
        .invalid (dec_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH0;
            pc_q    <= PC_RESET;
            cnt_q   <= 4'd0;
            len_q   <= 4'd0;
            buf_q   <= '0;
            stat_q  <= STAT_AOK;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            stat_q  <= stat_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        buf_d   = buf_q;
        stat_d  = stat_q;
        idle_d  = 1'b0;
        ack_ok  = req_w && bus.imem_ack;
        cnt_inc = cnt_q + 4'd1;

        case (state_q)
            S_FETCH0: begin
                if (ack_ok) begin
                    idle_d = 1'b1;
                    if (bus.imem_err) begin
                        stat_d  = STAT_ADR;
                        state_d = S_STOP;
                    end else if (dec_invalid) begin
                        stat_d  = STAT_INS;
                        state_d = S_STOP;
                    end else begin
                        buf_d[7:0] = bus.imem_rdata;
                        len_d      = dec_len;
                        if (dec_len == 4'd1) begin
                            state_d = S_PRESENT;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = S_FETCHN;
                        end
                    end
                end
            end
            S_FETCHN: begin
                if (ack_ok) begin
                    idle_d = 1'b1;
                    if (bus.imem_err) begin
                        stat_d  = STAT_ADR;
                        state_d = S_STOP;
                    end else begin
                        for (int k = 1; k < MAX_LEN; k++) begin
                            if (cnt_q == 4'(k)) begin
                                buf_d[8*k +: 8] = bus.imem_rdata;
                            end
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_PRESENT;
                        end
                    end
                end
            end
            S_PRESENT: begin
                if (bus.instr_ready) begin
                    if (buf_q[7:4] == I_HALT) begin
                        stat_d  = STAT_HLT;
                        state_d = S_STOP;
                    end else begin
                        pc_d    = bus.redirect_valid ? bus.redirect_pc
                                                     : (pc_q + 64'(len_q));
                        buf_d   = '0;
                        cnt_d   = 4'd0;
                        state_d = S_FETCH0;
                    end
                end
            end
            default: begin
                state_d = S_STOP;
            end
        endcase
    end

    always_comb begin
        req_w            = ((state_q == S_FETCH0) || (state_q == S_FETCHN)) && !idle_q;
        bus.imem_req     = req_w;
        bus.imem_addr    = pc_q + 64'(cnt_q);
        bus.instr_valid  = (state_q == S_PRESENT);
        bus.instr_bytes  = buf_q;
        bus.instr_len    = len_q;
        bus.pc           = pc_q;
        bus.valp         = pc_q + 64'(len_q);
        bus.stat         = stat_q;
        bus.halted       = (state_q == S_STOP);
    end

endmodule
